// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bit_a;
  logic             bit_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  bit_a, bit_b, busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output bit_a, bit_b, busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two operands, adds LSB first one bit per cycle,
// then pulses done for one cycle with the registered sum and carry.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             half_d;
  logic             sum_bit_d;
  logic             carry_d;

  // Full adder as two half-adder stages plus an OR.
  always_comb begin
    half_d    = a_q[0] ^ b_q[0];
    sum_bit_d = half_d ^ carry_q;
    carry_d   = (a_q[0] & b_q[0]) | (carry_q & half_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Operands drain right; result bits enter from the MSB side.
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          res_q   <= {sum_bit_d, res_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.bit_a     = a_q[0];
  assign bus.bit_b     = b_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = res_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, reset,
// ignored-start, mid-operation reset and back-to-back corner cases.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;
  } vec_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    exp_t e;
    full = {1'b0, a} + {1'b0, b};
    e.sum = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    sb.push_back(e);
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_sum"}, 32'(bus.sum), 32'(e.sum));
      check({name, "_co"}, 32'(bus.carry_out), 32'(e.co));
    end
  endtask

  // One full operation; inject pulses start and scrambles a/b mid-SHIFT.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit inject, input string name);
    logic [WIDTH-1:0] sum_hold;
    logic             co_hold;
    push_exp(a, b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      check({name, "_done_early"}, 32'(bus.done), 32'd0);
      check({name, "_bit_a"}, 32'(bus.bit_a), 32'(a[i]));
      check({name, "_bit_b"}, 32'(bus.bit_b), 32'(b[i]));
      if (inject && i == 2) begin
        bus.start = 1'b1;
        bus.a     = ~a;
        bus.b     = 8'h77;
      end
      if (inject && i == 4) bus.start = 1'b0;
      @(negedge clk);
    end
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check_result(name);
    sum_hold = bus.sum;
    co_hold  = bus.carry_out;
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({name, "_hold_sum"}, 32'(bus.sum), 32'(sum_hold));
    check({name, "_hold_co"}, 32'(bus.carry_out), 32'(co_hold));
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
    check({name, "_sum"}, 32'(bus.sum), 32'd0);
    check({name, "_co"}, 32'(bus.carry_out), 32'd0);
    check({name, "_bit_a"}, 32'(bus.bit_a), 32'd0);
    check({name, "_bit_b"}, 32'(bus.bit_b), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    bit   saw_done;
    int   cyc;
    int   prev_done;
    int   ndone;
    int   bidx;
    logic [WIDTH-1:0] ba;
    logic [WIDTH-1:0] bb;

    checks = 0;
    errors = 0;
    vecs[0] = '{a: 8'hA5, b: 8'h5A, exp_sum: 8'hFF, exp_co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp_sum: 8'h00, exp_co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, exp_sum: 8'hFE, exp_co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, exp_sum: 8'h00, exp_co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, exp_sum: 8'h00, exp_co: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, exp_sum: 8'h80, exp_co: 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: the DUT result must match both the model and the table.
    for (int v = 0; v < 6; v++) begin
      do_op(vecs[v].a, vecs[v].b, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_sum", v), 32'(bus.sum), 32'(vecs[v].exp_sum));
      check($sformatf("vec%0d_tbl_co", v), 32'(bus.carry_out), 32'(vecs[v].exp_co));
    end

    // Start and operand changes during SHIFT are ignored.
    do_op(8'h0F, 8'h01, 1'b1, "ignored_start");
    check("ignored_start_sum", 32'(bus.sum), 32'h10);
    @(negedge clk);
    check("ignored_start_no_restart", 32'(bus.busy), 32'd0);

    // Reset in the 4th SHIFT cycle aborts without a done pulse.
    bus.a     = 8'h55;
    bus.b     = 8'h33;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    do_op(8'h03, 8'h04, 1'b0, "after_rst");
    check("after_rst_sum", 32'(bus.sum), 32'h07);

    // Start coincident with reset is discarded.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_discard_busy", 32'(bus.busy), 32'd0);
    check("rst_start_discard_sum", 32'(bus.sum), 32'd0);

    // Back-to-back with start held: done pulses WIDTH+2 cycles apart.
    ba = 8'h96;
    bb = 8'h3C;
    for (int i = 0; i < 3; i++) push_exp(ba, bb);
    bus.a     = ba;
    bus.b     = bb;
    bus.start = 1'b1;
    cyc       = 0;
    prev_done = -1;
    ndone     = 0;
    bidx      = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) begin
        if (bidx < int'(WIDTH)) begin
          check("b2b_bit_a", 32'(bus.bit_a), 32'(ba[bidx]));
          check("b2b_bit_b", 32'(bus.bit_b), 32'(bb[bidx]));
        end
        bidx++;
      end else begin
        bidx = 0;
      end
      if (bus.done) begin
        ndone++;
        check_result("b2b");
        if (prev_done >= 0) check("b2b_spacing", 32'(cyc - prev_done), 32'd10);
        prev_done = cyc;
        if (ndone == 3) bus.start = 1'b0;
      end
    end
    check("b2b_done_count", 32'(ndone), 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("b2b_stopped", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
